apa102_out: RTL and testbench

//  APA102 frame transmitter; downstream neighbour of the apa102_in SPI receiver.
//  On a start pulse it latches NUM_LEDS x 24-bit colour words, e.g. the 168-bit receiver data_out.
//  It then emits one complete APA102 frame on sck/sda to drive or re-chain a strip:
//  32-bit zero start frame, NUM_LEDS LED frames, END_BITS end frame of ones.

---
 rtl/apa102_pkg.sv | 32 +++
 rtl/apa102_sck_gen.sv | 50 +++++
 rtl/apa102_out.sv | 182 ++++++++++++++++++
 tb/tb_apa102_out.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apa102_pkg.sv
// -----------------------------------------------------------------------------
// apa102_pkg
// Shared constants and types for the APA102 link (apa102_out transmitter and
// the apa102_in receiver).
//   START_BITS / LED_BITS / COLOR_BITS : frame geometry
//   LED_HDR                            : fixed top bits of every LED frame
//   END_FILL                           : value shifted during the end frame
//   state_t                            : frame sequencer states
//   led_word()                         : assemble one 32-bit LED frame
// -----------------------------------------------------------------------------
package apa102_pkg;

  localparam int         START_BITS = 32;
  localparam int         LED_BITS   = 32;
  localparam int         COLOR_BITS = 24;
  localparam logic [2:0] LED_HDR    = 3'b111;
  localparam logic       END_FILL   = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_FRM = 2'd1,
    LED_FRM   = 2'd2,
    END_FRM   = 2'd3
  } state_t;

  // One LED frame, MSB-first on the wire: header, 5-bit brightness, colour.
  function automatic logic [LED_BITS-1:0] led_word(input logic [4:0] bright,
                                                   input logic [COLOR_BITS-1:0] color);
    return {LED_HDR, bright, color};
  endfunction

endpackage

// File: rtl/apa102_sck_gen.sv
// -----------------------------------------------------------------------------
// apa102_sck_gen
// Serial clock generator: sck toggles every CLK_DIV enabled clk cycles, so one
// sck period is 2*CLK_DIV cycles and each period starts with the low half.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   enable   in  run the divider; when low the divider is held at its reset state
//   sck      out registered serial clock, idles low
//   rise_stb out high in the cycle whose closing edge raises sck
//   fall_stb out high in the cycle whose closing edge lowers sck
// -----------------------------------------------------------------------------
module apa102_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             half_end_s;

  assign half_end_s = enable && (div_cnt_r == DIV_MAX);
  assign rise_stb   = half_end_s && !sck;
  assign fall_stb   = half_end_s && sck;

  // Divider counter and sck toggle flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
      sck       <= 1'b0;
    end else if (!enable) begin
      div_cnt_r <= '0;
      sck       <= 1'b0;
    end else if (half_end_s) begin
      div_cnt_r <= '0;
      sck       <= ~sck;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/apa102_out.sv
// -----------------------------------------------------------------------------
// apa102_out
// APA102 frame transmitter. On an accepted start it snapshots the colour words
// and sends one frame: 32 zero bits, NUM_LEDS LED frames, END_BITS one bits.
// Optional feature macro: APA102_OUT_BRIGHTNESS_EN adds the brightness[4:0]
// input (latched at start); without it every LED frame uses brightness 5'h1F.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset (aborts a frame immediately)
//   start      in  frame request, honoured only while busy is low
//   data_in    in  24*NUM_LEDS colours, top word = LED0 (sent first)
//   brightness in  5-bit global brightness (only with APA102_OUT_BRIGHTNESS_EN)
//   busy       out frame in progress
//   done       out one-cycle pulse after the last bit
//   sck        out serial clock to the strip, idles low
//   sda        out serial data, changes only while sck is low
// -----------------------------------------------------------------------------
module apa102_out
  import apa102_pkg::*;
#(
  parameter int NUM_LEDS = 7,
  parameter int CLK_DIV  = 4,
  parameter int END_BITS = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [COLOR_BITS*NUM_LEDS-1:0] data_in,
`ifdef APA102_OUT_BRIGHTNESS_EN
  input  logic [4:0]                   brightness,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         sck,
  output logic                         sda
);

  localparam int               LED_TOTAL  = LED_BITS * NUM_LEDS;
  localparam int               TOTAL_BITS = START_BITS + LED_TOTAL + END_BITS;
  localparam int               CNT_W      = $clog2(TOTAL_BITS);
  localparam logic [CNT_W-1:0] LAST_START = CNT_W'(START_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_LED   = CNT_W'(START_BITS + LED_TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(TOTAL_BITS - 1);

  state_t               state_r, state_nxt;
  logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_nxt;
  logic [LED_TOTAL-1:0] frame_sr_r, frame_sr_nxt;
  logic                 sda_r, sda_nxt;
  logic                 done_r, done_nxt;
  logic                 busy_r, busy_nxt;
  logic [LED_TOTAL-1:0] load_frames_s;
  logic [4:0]           bright_s;
  logic                 rise_stb_s;
  logic                 fall_stb_s;
  logic                 unused_s;

`ifdef APA102_OUT_BRIGHTNESS_EN
  assign bright_s = brightness;
`else
  assign bright_s = 5'h1F;
`endif

  // The strip samples on the rising edge; this side only acts on the falling one.
  assign unused_s = rise_stb_s;

  assign busy = busy_r;
  assign done = done_r;
  assign sda  = sda_r;

  apa102_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (busy_r),
    .sck      (sck),
    .rise_stb (rise_stb_s),
    .fall_stb (fall_stb_s)
  );

  // Pre-assemble all LED frames so the snapshot taken at start is the exact bit
  // stream; brightness is therefore latched together with the colours.
  always_comb begin
    load_frames_s = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      load_frames_s[LED_TOTAL-1-LED_BITS*i -: LED_BITS] =
        led_word(bright_s, data_in[COLOR_BITS*(NUM_LEDS-i)-1 -: COLOR_BITS]);
    end
  end

  // Frame sequencer: next state, bit counter, shift register and data bit.
  // sda is loaded with the next bit on the sck falling strobe so it is stable
  // for the whole high half.
  always_comb begin
    state_nxt    = state_r;
    bit_cnt_nxt  = bit_cnt_r;
    frame_sr_nxt = frame_sr_r;
    sda_nxt      = sda_r;
    done_nxt     = 1'b0;
    case (state_r)
      IDLE: begin
        sda_nxt = 1'b0;
        if (start) begin
          state_nxt    = START_FRM;
          bit_cnt_nxt  = '0;
          frame_sr_nxt = load_frames_s;
        end else begin
          state_nxt = IDLE;
        end
      end
      START_FRM: begin
        if (fall_stb_s) begin
          bit_cnt_nxt = bit_cnt_r + CNT_W'(1);
          if (bit_cnt_r == LAST_START) begin
            state_nxt = LED_FRM;
            sda_nxt   = frame_sr_r[LED_TOTAL-1];
          end else begin
            sda_nxt = 1'b0;
          end
        end else begin
          state_nxt = START_FRM;
        end
      end
      LED_FRM: begin
        if (fall_stb_s) begin
          bit_cnt_nxt  = bit_cnt_r + CNT_W'(1);
          frame_sr_nxt = frame_sr_r << 1;
          if (bit_cnt_r == LAST_LED) begin
            state_nxt = END_FRM;
            sda_nxt   = END_FILL;
          end else begin
            sda_nxt = frame_sr_r[LED_TOTAL-2];
          end
        end else begin
          state_nxt = LED_FRM;
        end
      end
      END_FRM: begin
        if (fall_stb_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            sda_nxt     = 1'b0;
            done_nxt    = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt_r + CNT_W'(1);
            sda_nxt     = END_FILL;
          end
        end else begin
          state_nxt = END_FRM;
        end
      end
      default: begin
        state_nxt    = IDLE;
        bit_cnt_nxt  = '0;
        frame_sr_nxt = '0;
        sda_nxt      = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Sequencer registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bit_cnt_r  <= '0;
      frame_sr_r <= '0;
      sda_r      <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      bit_cnt_r  <= bit_cnt_nxt;
      frame_sr_r <= frame_sr_nxt;
      sda_r      <= sda_nxt;
      done_r     <= done_nxt;
      busy_r     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_apa102_out.sv
// -----------------------------------------------------------------------------
// tb_apa102_out
// Self-checking bench: a default instance (7 LEDs, CLK_DIV 4, 32 end bits) and
// a small one (1 LED, CLK_DIV 1, 8 end bits). Frames are decoded on sck rise and
// compared with a bit list built from the APA102 frame rules.
// -----------------------------------------------------------------------------
module tb_apa102_out;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic [167:0] data_a = '0;
  logic [23:0]  data_b = '0;
  logic         busy_a, done_a, sck_a, sda_a;
  logic         busy_b, done_b, sck_b, sda_b;
  logic [4:0]   cur_br = 5'h1F;
`ifdef APA102_OUT_BRIGHTNESS_EN
  logic [4:0]   brightness = 5'h1F;
`endif

  always #5 clk = ~clk;

  apa102_out #(.NUM_LEDS(7), .CLK_DIV(4), .END_BITS(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_a),
`ifdef APA102_OUT_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .busy(busy_a), .done(done_a), .sck(sck_a), .sda(sda_a));

  apa102_out #(.NUM_LEDS(1), .CLK_DIV(1), .END_BITS(8)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_b),
`ifdef APA102_OUT_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .busy(busy_b), .done(done_b), .sck(sck_b), .sda(sda_b));

  // Monitor mux: sel=0 watches the default instance, sel=1 the small one.
  logic sel = 1'b0;
  logic m_busy, m_done, m_sck, m_sda;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_sck  = sel ? sck_b  : sck_a;
  assign m_sda  = sel ? sda_b  : sda_a;

  int n_checks = 0;
  int n_pass   = 0;
  bit cap_q[$];
  bit exp_q[$];
  int rise_cyc, done_cyc, viol;
  bit got_done;
  logic prev_sck, prev_sda, prev_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_bright(input logic [4:0] v);
`ifdef APA102_OUT_BRIGHTNESS_EN
    brightness = v;
    cur_br     = v;
`else
    cur_br     = 5'h1F;
`endif
  endtask

  // Reference bit stream: zero start frame, LED frames MSB-first, ones.
  task automatic build_exp(input int nleds, input int endb, input logic [167:0] colors,
                           input logic [4:0] br);
    logic [31:0] w;
    exp_q.delete();
    repeat (32) exp_q.push_back(1'b0);
    for (int i = 0; i < nleds; i++) begin
      w = {3'b111, br, colors[24*(nleds-i)-1 -: 24]};
      for (int b = 31; b >= 0; b--) exp_q.push_back(w[b]);
    end
    repeat (endb) exp_q.push_back(1'b1);
  endtask

  // Decode the selected instance on sck rise until done, a bit limit or timeout.
  task automatic collect(input int max_bits, input int budget);
    cap_q.delete();
    viol = 0; rise_cyc = -1; done_cyc = -1; got_done = 1'b0;
    prev_sck = m_sck; prev_sda = m_sda; prev_busy = m_busy;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (m_busy && !prev_busy && rise_cyc < 0) rise_cyc = c;
      if (m_sck && !prev_sck) cap_q.push_back(m_sda);
      if (m_sck && prev_sck && (m_sda !== prev_sda)) viol++;
      prev_sck = m_sck; prev_sda = m_sda; prev_busy = m_busy;
      if (m_done) begin
        got_done = 1'b1;
        done_cyc = c;
        break;
      end
      if (max_bits > 0 && cap_q.size() >= max_bits) break;
    end
  endtask

  task automatic pulse_and_collect(input bit s, input int budget);
    sel = s;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    fork
      collect(0, budget);
      begin
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
      end
    join
  endtask

  task automatic check_frame(input string tag, input int div);
    logic [31:0] o, e;
    int idx;
    check({tag, "_done"}, 64'(got_done), 64'd1);
    check({tag, "_len"}, 64'(cap_q.size()), 64'(exp_q.size()));
    check({tag, "_cycles"}, 64'(done_cyc - rise_cyc), 64'(exp_q.size() * 2 * div));
    check({tag, "_sda_hold"}, 64'(viol), 64'd0);
    check({tag, "_idle_at_done"}, {61'd0, m_busy, m_sck, m_sda}, 64'd0);
    for (int w = 0; w * 32 < exp_q.size(); w++) begin
      o = '0; e = '0;
      for (int j = 0; j < 32; j++) begin
        idx = w * 32 + j;
        if (idx < exp_q.size()) begin
          e = {e[30:0], exp_q[idx]};
          o = {o[30:0], (idx < cap_q.size()) ? cap_q[idx] : 1'b0};
        end
      end
      check($sformatf("%s_word%0d", tag, w), 64'(o), 64'(e));
    end
  endtask

  function automatic logic [167:0] rand168();
    logic [167:0] r;
    for (int i = 0; i < 6; i++) r[32*i +: 32] = $urandom;
    r[167:160] = 8'($urandom);
    return r;
  endfunction

  initial begin
    logic [167:0] x, y;
    logic [7:0]   hdr, exp_hdr;
    int           errs;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst_a", {60'd0, sck_a, sda_a, busy_a, done_a}, 64'd0);
    check("rst_b", {60'd0, sck_b, sda_b, busy_b, done_b}, 64'd0);
    rst_n = 1'b1;

    // Idle for 100 cycles with no start.
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (sck_a | sda_a | busy_a | done_a | sck_b | sda_b | busy_b | done_b) errs++;
    end
    check("idle100", 64'(errs), 64'd0);

    // Directed frame: LED0 red, all others off.
    set_bright(5'h1F);
    data_a = {24'hFF0000, 144'h0};
    build_exp(7, 32, data_a, cur_br);
    pulse_and_collect(1'b0, 5000);
    check_frame("red", 4);

    // Random colours and brightness.
    for (int n = 0; n < 2; n++) begin
      set_bright(5'($urandom));
      data_a = rand168();
      build_exp(7, 32, data_a, cur_br);
      pulse_and_collect(1'b0, 5000);
      check_frame($sformatf("rnd%0d", n), 4);
    end

    // start held high: back-to-back frames; mid-frame data change goes to frame 2.
    sel = 1'b0;
    x = rand168();
    y = rand168();
    data_a = x;
    start_a = 1'b1;
    fork
      collect(0, 5000);
      begin
        repeat (1000) @(negedge clk);
        data_a = y;
      end
    join
    build_exp(7, 32, x, cur_br);
    check_frame("b2b1", 4);
    fork
      collect(0, 5000);
      begin
        @(negedge clk);
        start_a = 1'b0;
        repeat (500) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
      end
    join
    check("b2b_gap", 64'(rise_cyc), 64'd1);
    build_exp(7, 32, y, cur_br);
    check_frame("b2b2", 4);
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a) errs++;
    end
    check("no_queue", 64'(errs), 64'd0);

    // Asynchronous reset at bit 100 aborts the frame.
    data_a = rand168();
    start_a = 1'b1;
    fork
      collect(100, 5000);
      begin
        @(negedge clk);
        start_a = 1'b0;
      end
    join
    check("abort_bits", 64'(cap_q.size()), 64'd100);
    rst_n = 1'b0;
    #1;
    check("abort_async", {61'd0, sck_a, busy_a, sda_a}, 64'd0);
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_a | busy_a | sck_a) errs++;
    end
    check("abort_quiet", 64'(errs), 64'd0);
    rst_n = 1'b1;
    data_a = rand168();
    build_exp(7, 32, data_a, cur_br);
    pulse_and_collect(1'b0, 5000);
    check_frame("after_rst", 4);

    // Small instance: 72 bits, 2-cycle sck period.
    for (int n = 0; n < 3; n++) begin
      data_b = 24'($urandom);
      build_exp(1, 8, {144'd0, data_b}, cur_br);
      pulse_and_collect(1'b1, 500);
      check_frame($sformatf("small%0d", n), 1);
    end

    // Header byte with brightness 3 (fixed 8'hFF when the port is absent).
    set_bright(5'h03);
`ifdef APA102_OUT_BRIGHTNESS_EN
    exp_hdr = 8'hE3;
`else
    exp_hdr = 8'hFF;
`endif
    data_a = rand168();
    build_exp(7, 32, data_a, cur_br);
    pulse_and_collect(1'b0, 5000);
    hdr = '0;
    for (int j = 32; j < 40; j++) hdr = {hdr[6:0], (j < cap_q.size()) ? cap_q[j] : 1'b0};
    check("hdr_byte", 64'(hdr), 64'(exp_hdr));
    check_frame("bright", 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
